// File: rtl/dual_rail_encoder.sv
// rtl/dual_rail_encoder.sv - registered dual-rail 4-bit binary-to-Gray encoder with NULL/DATA hysteresis

module dual_rail_class (
    input  logic [3:0] rail_t,
    input  logic [3:0] rail_f,
    output logic       is_data,
    output logic       is_null,
    output logic       is_illegal
);
    // A pair is DATA only when exactly one rail is high, so (1,1) can never count as DATA.
    assign is_illegal = |(rail_t & rail_f);
    assign is_data    = &(rail_t ^ rail_f);
    assign is_null    = ~|(rail_t | rail_f);
endmodule

module dual_rail_encoder (
    input  logic clk,
    input  logic rst,
    input  logic A_t,
    input  logic A_f,
    input  logic B_t,
    input  logic B_f,
    input  logic C_t,
    input  logic C_f,
    input  logic D_t,
    input  logic D_f,
    output logic out3_t,
    output logic out3_f,
    output logic out2_t,
    output logic out2_f,
    output logic out1_t,
    output logic out1_f,
    output logic out0_t,
    output logic out0_f,
    output logic complete,
    output logic err
);
    typedef enum logic {
        S_NULL = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] out_t_q, out_t_d;
    logic [3:0] out_f_q, out_f_d;
    logic       err_q, err_d;

    logic [3:0] in_t, in_f;
    logic [3:0] gray;
    logic       in_data, in_null, in_illegal;

    assign in_t = {A_t, B_t, C_t, D_t};
    assign in_f = {A_f, B_f, C_f, D_f};

    dual_rail_class u_class (
        .rail_t     (in_t),
        .rail_f     (in_f),
        .is_data    (in_data),
        .is_null    (in_null),
        .is_illegal (in_illegal)
    );

    // On a complete DATA word the _t rails are the binary value.
    assign gray = {in_t[3], in_t[3] ^ in_t[2], in_t[2] ^ in_t[1], in_t[1] ^ in_t[0]};

    always_comb begin
        state_d = state_q;
        out_t_d = out_t_q;
        out_f_d = out_f_q;
        err_d   = err_q | in_illegal;
        case (state_q)
            S_NULL: begin
                if (!in_illegal && in_data) begin
                    state_d = S_DATA;
                    out_t_d = gray;
                    out_f_d = ~gray;
                end
            end
            S_DATA: begin
                // Only a full NULL wavefront releases the held word.
                if (!in_illegal && in_null) begin
                    state_d = S_NULL;
                    out_t_d = 4'b0000;
                    out_f_d = 4'b0000;
                end
            end
            default: begin
                state_d = S_NULL;
                out_t_d = 4'b0000;
                out_f_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NULL;
            out_t_q <= 4'b0000;
            out_f_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_t_q <= out_t_d;
            out_f_q <= out_f_d;
            err_q   <= err_d;
        end
    end

    assign {out3_t, out2_t, out1_t, out0_t} = out_t_q;
    assign {out3_f, out2_f, out1_f, out0_f} = out_f_q;
    assign complete = (state_q == S_DATA);
    assign err      = err_q;
endmodule

// File: tb/tb_dual_rail_encoder.sv
// tb/tb_dual_rail_encoder.sv - directed and randomized checks of dual_rail_encoder against a word-level model

module tb_dual_rail_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in_t = 4'b0000;
    logic [3:0] in_f = 4'b0000;
    logic A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f;
    logic out3_t, out3_f, out2_t, out2_f, out1_t, out1_f, out0_t, out0_f;
    logic complete, err;

    int checks = 0;
    int errors = 0;

    logic       m_complete = 1'b0;
    logic       m_err = 1'b0;
    logic [3:0] m_gray = 4'b0000;

    assign {A_t, B_t, C_t, D_t} = in_t;
    assign {A_f, B_f, C_f, D_f} = in_f;

    always #5 clk = ~clk;

    dual_rail_encoder dut (
        .clk(clk), .rst(rst),
        .A_t(A_t), .A_f(A_f), .B_t(B_t), .B_f(B_f),
        .C_t(C_t), .C_f(C_f), .D_t(D_t), .D_f(D_f),
        .out3_t(out3_t), .out3_f(out3_f), .out2_t(out2_t), .out2_f(out2_f),
        .out1_t(out1_t), .out1_f(out1_f), .out0_t(out0_t), .out0_f(out0_f),
        .complete(complete), .err(err)
    );

    function automatic logic [9:0] observed();
        return {out3_t, out2_t, out1_t, out0_t, out3_f, out2_f, out1_f, out0_f, complete, err};
    endfunction

    function automatic logic [9:0] expect_vec(input logic c, input logic [3:0] g, input logic e);
        return c ? {g, ~g, 1'b1, e} : {8'h00, 1'b0, e};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Word-level reference: classify the whole input, then apply the hysteresis rules.
    task automatic model_update(input logic [3:0] t, input logic [3:0] f, input logic r);
        int x;
        if (r) begin
            m_complete = 1'b0;
            m_gray     = 4'b0000;
            m_err      = 1'b0;
        end else if ((t & f) != 4'b0000) begin
            m_err = 1'b1;
        end else if (!m_complete && (t | f) == 4'hF) begin
            x          = int'(t);
            m_gray     = 4'(x ^ (x / 2));
            m_complete = 1'b1;
        end else if (m_complete && (t | f) == 4'h0) begin
            m_complete = 1'b0;
        end
    endtask

    task automatic step(input logic [3:0] t, input logic [3:0] f, input logic r);
        in_t = t;
        in_f = f;
        rst  = r;
        @(posedge clk);
        model_update(t, f, r);
        #1;
        check("model", observed(), expect_vec(m_complete, m_gray, m_err));
    endtask

    task automatic data(input logic [3:0] x);
        step(x, ~x, 1'b0);
    endtask

    task automatic nullw();
        step(4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] rt, rf;
        int mode, code;

        step(4'b1111, 4'b0000, 1'b1);
        check("reset", observed(), 10'b0);

        nullw();
        for (int x = 0; x < 16; x++) begin
            for (int k = 0; k < 10; k++) data(4'(x));
            case (x)
                8:  check("gray_1000", observed(), expect_vec(1'b1, 4'b1100, 1'b0));
                13: check("gray_1101", observed(), expect_vec(1'b1, 4'b1011, 1'b0));
                15: check("gray_1111", observed(), expect_vec(1'b1, 4'b1000, 1'b0));
                6:  check("gray_0110", observed(), expect_vec(1'b1, 4'b0101, 1'b0));
                10: check("gray_1010", observed(), expect_vec(1'b1, 4'b1111, 1'b0));
                default: ;
            endcase
            for (int k = 0; k < 10; k++) nullw();
            check("null_after_data", observed(), 10'b0);
        end

        step(4'b1000, 4'b0100, 1'b0);
        step(4'b1000, 4'b0100, 1'b0);
        check("partial_hold", observed(), 10'b0);
        data(4'b1011);
        check("partial_complete", observed(), expect_vec(1'b1, 4'b1110, 1'b0));

        nullw();
        data(4'b1101);
        check("pre_change", observed(), expect_vec(1'b1, 4'b1011, 1'b0));
        data(4'b0000);
        data(4'b0000);
        check("no_null_hold", observed(), expect_vec(1'b1, 4'b1011, 1'b0));
        nullw();
        data(4'b0000);
        check("zero_word", observed(), 10'b0000_1111_10);

        nullw();
        data(4'b1000);
        step(4'b1010, 4'b1101, 1'b0);
        check("illegal", observed(), expect_vec(1'b1, 4'b1100, 1'b1));
        nullw();
        check("err_sticky_null", observed(), expect_vec(1'b0, 4'b0000, 1'b1));
        data(4'b0110);
        check("err_sticky_data", observed(), expect_vec(1'b1, 4'b0101, 1'b1));
        nullw();
        step(4'b1111, 4'b1111, 1'b0);
        check("illegal_from_null", observed(), expect_vec(1'b0, 4'b0000, 1'b1));

        step(4'b0000, 4'b0000, 1'b1);
        data(4'b1111);
        check("pre_reset", observed(), expect_vec(1'b1, 4'b1000, 1'b0));
        step(4'b1111, 4'b0000, 1'b1);
        check("reset_mid_data", observed(), 10'b0);

        for (int n = 0; n < 400; n++) begin
            mode = $urandom_range(0, 19);
            rt = 4'b0000;
            rf = 4'b0000;
            if (mode < 7) begin
                rt = 4'b0000;
            end else if (mode < 15) begin
                rt = 4'($urandom_range(0, 15));
                rf = ~rt;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    code = (mode == 19) ? $urandom_range(0, 3) : $urandom_range(0, 2);
                    rt[b] = (code == 2) || (code == 3);
                    rf[b] = (code == 1) || (code == 3);
                end
            end
            step(rt, rf, ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
